// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter and sequencer for a shared 4:1 packet mux; grant is held until the last beat.
// Optional stall timeout is enabled by defining ARB_TIMEOUT_EN.
module rr_mux_arbiter_4 #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_last,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [3:0]          grant,
  output logic [1:0]          sel,
  output logic                busy,
  output logic                timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  grant_nxt;
  logic [1:0]  sel_nxt;
  logic        busy_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [2:0]  pick;
  logic        release_now;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_mux_arbiter_4: MAX_HOLD must be 2..255");
  end

  // Returns {found, index}: first set bit of r searching start, start+1, ... (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    in_ready  = '0;
    if (state == GRANT) begin
      out_valid = req[sel];
      out_data  = in_data[sel*DATA_W +: DATA_W];
      out_last  = in_last[sel];
      in_ready  = grant & {4{out_ready}};
    end
  end

  assign release_now = (state == GRANT) && ((out_valid && out_ready && out_last) || timeout);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] stall_cnt;

  // Only cycles where the granted lane has nothing to offer count; sink backpressure does not.
  assign timeout = (state == GRANT) && !req[sel] && (stall_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state != GRANT || req[sel] || release_now) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    busy_nxt  = busy;
    ptr_nxt   = ptr;
    pick      = '0;
    case (state)
      IDLE: begin
        pick = rr_pick(req, ptr);
        if (pick[2]) begin
          state_nxt = GRANT;
          grant_nxt = 4'(4'b0001 << pick[1:0]);
          sel_nxt   = pick[1:0];
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          // The released lane is masked out so it only wins again via IDLE when nobody else asks.
          ptr_nxt = sel + 2'd1;
          pick    = rr_pick(req & ~grant, sel + 2'd1);
          if (pick[2]) begin
            grant_nxt = 4'(4'b0001 << pick[1:0]);
            sel_nxt   = pick[1:0];
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            sel_nxt   = '0;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      sel   <= sel_nxt;
      busy  <= busy_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 data multiplexer. Four requesters compete for one output channel.
- Grants exactly one requester at a time and holds the grant for a whole packet, until the beat marked last is accepted.
- Drives the 2-bit mux select and a one-hot grant vector, and routes valid/ready handshakes between the winner and the downstream sink.
- Sits between four packet sources and a single downstream consumer.

Parameters:
- DATA_W, 8, width of each requester's data lane and of out_data.
- MAX_HOLD, 16, stall-cycle limit before a grant is revoked. Used only with ARB_TIMEOUT_EN; must be 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester request/valid; bit i high = lane i has a beat available.
- in_data  input  4*DATA_W  packed lanes; lane i = bits [i*DATA_W +: DATA_W].
- in_last  input  4  per-lane last-beat flag.
- in_ready  output  4  per-lane ready; only the granted bit can be high.
- out_valid  output  1  beat valid to the sink.
- out_data  output  DATA_W  muxed data.
- out_last  output  1  muxed last flag.
- out_ready  input  1  sink ready.
- grant  output  4  one-hot registered grant; 0 when idle.
- sel  output  2  encoded grant index; drives the mux select.
- busy  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse on a forced revoke; tied 0 when the feature is off.

Behaviour:
- Reset (async, rst_n low): grant=0, sel=0, busy=0, round-robin pointer ptr=0, state=IDLE. Combinational outputs then read out_valid=0, in_ready=0, out_last=0, out_data=0, timeout=0. Reset mid-packet discards the packet; no partial-release action.
- States: IDLE and GRANT.
- IDLE:
  - If req is nonzero, select the winner by searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
  - Next edge: grant=onehot(winner), sel=winner, busy=1, state=GRANT.
  - Arbitration latency is 1 cycle from req to grant.
- GRANT, with g=sel:
  - out_valid=req[g], out_data=in_data lane g, out_last=in_last[g], in_ready[g]=out_ready. All other in_ready bits are 0. These are combinational.
  - Transfer = out_valid & out_ready.
  - Transfer with out_last=1 (release): ptr <= g+1 mod 4. In the same cycle, search the other requests from g+1 for the next winner.
    - Next winner found: next edge loads the new grant directly (zero-bubble back-to-back).
    - No other request: next edge goes to IDLE, grant=0, busy=0.
    - The released lane is only regranted if no other lane is requesting. The search order ends at g, so ptr advancing to g+1 enforces this.
  - req[g] dropping mid-packet: out_valid=0, grant held. No release without a last transfer.
- Requests from non-granted lanes are ignored. They see in_ready=0 and must hold their data.
- Single-beat packet (last on the first beat) is legal: grant lasts 1 cycle if the sink is ready.
- Fairness: with all four lanes requesting continuously, grant order from reset is 0,1,2,3,0,…

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A stall counter (8 bit) counts consecutive GRANT cycles with req[g]=0. It clears on any cycle with req[g]=1 and on every grant change.
  - When the counter reaches MAX_HOLD, the grant is revoked as if released: ptr <= g+1, next winner searched as on release, and timeout pulses high for that cycle.
  - Stalls caused by out_ready=0 with req[g]=1 do not count.
- Undefined: no counter logic; timeout is constant 0; grants are held indefinitely.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0 → grant=0, sel=0, busy=0, out_valid=0 for 10 cycles.
- Single request: req=4'b0100, 3-beat packet, last on beat 3, out_ready=1 → grant=4'b0100 and sel=2 one cycle after req. out_data follows lane 2. Grant drops after the last beat; ptr=3.
- Round-robin: req=4'b1111 constant, 2-beat packets → grants 0,1,2,3,0 with no idle cycle between packets.
- Backpressure: lane 1 granted, out_ready=0 for 5 cycles → in_ready[1]=0, grant held, out_data stable. Transfer completes once out_ready=1.
- Mid-packet gap and async reset: lane 3 deasserts req for 3 cycles mid-packet → out_valid=0 and grant held, no timeout. Then assert rst_n=0 between edges → grant=0 immediately.
- ARB_TIMEOUT_EN with MAX_HOLD=4: lane 0 granted, req[0]=0 → timeout pulses at the 4th stall cycle, grant moves to lane 1 if req[1]=1.
